// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S slave transmitter: default widths and word-select encoding.
package i2s_tx_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Word-select level on the wire: 0 selects the left channel, 1 the right.
  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

endpackage : i2s_tx_pkg

// File: rtl/i2s_tx_fifo.sv
// Single-clock frame FIFO with registered full/empty flags and occupancy level.
module i2s_tx_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_c, pop_c;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  always_comb begin
    push_c  = wr_valid_i & ~full_q;
    pop_c   = rd_en_i & ~empty_q;
    wptr_d  = push_c ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop_c  ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d   = cnt_q + LVL_W'(push_c) - LVL_W'(pop_c);
    full_d  = (cnt_d == LVL_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wptr_q] <= wr_data_i;
  end

  assign wr_ready_o = ~full_q;
  assign rd_data_o  = mem_q[rptr_q];
  assign empty_o    = empty_q;
  assign level_o    = cnt_q;

endmodule : i2s_tx_fifo

// File: rtl/i2s_tx.sv
// I2S slave transmitter: serialises queued {left,right} frames onto sd, MSB first,
// one bit after each ws transition, timed by an externally mastered i2s_clk/ws.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          i2s_clk,
  input  logic                          ws,
  output logic                          sd,
  input  logic [2*DATA_W-1:0]           wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  input  logic                          clr_underrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2:0]          sck_q;
  logic [1:0]          ws_s_q;
  ws_e                 ws_r_q, ws_r_d, ws_d_q, ws_d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d, hold_q, hold_d;
  logic                sd_q, sd_d;
  logic                underrun_q, underrun_d;
  logic                rise_c, fall_c, pop_c, set_ur_c;
  logic [DATA_W-1:0]   word_c;
  logic [2*DATA_W-1:0] fifo_rd_data;
  logic                fifo_empty;

  i2s_tx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .rd_en_i    (pop_c),
    .rd_data_o  (fifo_rd_data),
    .empty_o    (fifo_empty),
    .level_o    (level)
  );

  // sck_q[1:0] synchronise i2s_clk; sck_q[2] is the edge-detect delay stage.
  assign rise_c =  sck_q[1] & ~sck_q[2];
  assign fall_c = ~sck_q[1] &  sck_q[2];

  always_comb begin
    ws_r_d     = ws_r_q;
    ws_d_d     = ws_d_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    sd_d       = sd_q;
    pop_c      = 1'b0;
    set_ur_c   = 1'b0;
    word_c     = '0;

    if (rise_c) begin
      ws_d_d = ws_r_q;
      ws_r_d = ws_e'(ws_s_q[1]);
    end

    if (fall_c) begin
      if (ws_r_q != ws_d_q) begin
        // Channel start: a left start pops the next frame and parks its right word.
        cnt_d = CNT_W'(DATA_W - 1);
        if (ws_r_q == WS_LEFT) begin
          pop_c = 1'b1;
          if (fifo_empty) begin
            hold_d   = '0;
            set_ur_c = 1'b1;
          end else begin
            word_c = fifo_rd_data[2*DATA_W-1:DATA_W];
            hold_d = fifo_rd_data[DATA_W-1:0];
          end
        end else begin
          word_c = hold_q;
        end
        sd_d    = word_c[DATA_W-1];
        shift_d = {word_c[DATA_W-2:0], 1'b0};
      end else if (cnt_q != '0) begin
        cnt_d   = cnt_q - CNT_W'(1);
        sd_d    = shift_q[DATA_W-1];
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
      end else begin
        // Master slot longer than the word: pad with zeros.
        sd_d = 1'b0;
      end
    end

    underrun_d = set_ur_c | (underrun_q & ~clr_underrun);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sck_q      <= '0;
      ws_s_q     <= '0;
      ws_r_q     <= WS_RIGHT;
      ws_d_q     <= WS_RIGHT;
      cnt_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], i2s_clk};
      ws_s_q     <= {ws_s_q[0], ws};
      ws_r_q     <= ws_r_d;
      ws_d_q     <= ws_d_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
    end
  end

  assign sd       = sd_q;
  assign underrun = underrun_q;

endmodule : i2s_tx
